// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, framing constants and counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int UART_STOP_BITS = 1;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick pulses for one cycle every CLKS_PER_BIT cycles after clear drops.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Suppressed while cleared so an idle transmitter never sees a stray boundary.
  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_nbit.sv
// UART transmitter: 1 start bit, N data bits LSB first, stop bit(s), no parity.
module uart_tx_nbit
  import uart_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] data_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         tx
);

  localparam int BW = cnt_width(N);

  if (N < 5 || N > 9) begin : g_bad_n
    $error("uart_tx_nbit: N must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_nbit: CLKS_PER_BIT must be at least 2");
  end

  uart_state_t   state;
  logic [N-1:0]  shift_reg;
  logic [BW-1:0] bit_idx;
  logic          tick;

  // Timer is held at zero while idle, so the start bit always gets a full period.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  assign ready = ~busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= data_in;
            bit_idx   <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == BW'(N - 1)) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              tx      <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_idx == BW'(UART_STOP_BITS - 1)) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_nbit.sv
// Directed frame table plus corner sequences and a random stream decoded by a mid-bit monitor.
module tb_uart_tx_nbit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, busy, done, tx;

  int checks = 0;
  int errors = 0;

  uart_tx_nbit #(.N(8), .CLKS_PER_BIT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data_in(data_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [0:9] bits;  // serial order: start, d0..d7, stop
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge just before the accepting edge (load already driven).
  // Returns at the negedge of the done cycle.
  task automatic run_frame(input string nm, input logic [0:9] exp, input int inject_k,
                           input bit keep);
    @(negedge clk);
    if (!keep) begin
      load    = 1'b0;
      data_in = ~data_in;
    end
    for (int k = 0; k < 40; k++) begin
      chk({nm, "_tx"}, 32'(tx), 32'(exp[k/4]));
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_ready"}, 32'(ready), 32'd0);
      chk({nm, "_done_early"}, 32'(done), 32'd0);
      if (k == inject_k) begin
        load    = 1'b1;
        data_in = 8'hFF;
      end else if (inject_k >= 0 && k == inject_k + 1) begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_ready_end"}, 32'(ready), 32'd1);
    chk({nm, "_tx_idle"}, 32'(tx), 32'd1);
  endtask

  // Mid-bit sampling monitor for the random stream.
  logic       mon_en = 1'b0;
  logic [7:0] rx_q[$];
  int         done_cnt = 0;

  initial begin
    logic prev;
    logic [7:0] w;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && done) done_cnt++;
      if (mon_en && prev && !tx) begin
        repeat (2) @(negedge clk);
        chk("mon_start", 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge clk);
          w[j] = tx;
        end
        repeat (4) @(negedge clk);
        chk("mon_stop", 32'(tx), 32'd1);
        rx_q.push_back(w);
      end
      prev = tx;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_q[$];
    int accepted;
    int t;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h3C, 10'b0001111001};
    vecs[2] = '{8'h00, 10'b0000000001};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h81, 10'b0100000011};
    vecs[5] = '{8'h55, 10'b0101010101};
    vecs[6] = '{8'h01, 10'b0100000001};
    vecs[7] = '{8'h80, 10'b0000000011};

    // Reset state and idle line.
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    // Table of single frames.
    for (int v = 0; v < 8; v++) begin
      load    = 1'b1;
      data_in = vecs[v].d;
      run_frame($sformatf("vec%0d", v), vecs[v].bits, -1, 1'b0);
      @(negedge clk);
      chk("vec_done_pulse", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
    end

    // Load of 0xFF during a 0x3C frame is ignored; only one done pulse.
    load    = 1'b1;
    data_in = 8'h3C;
    run_frame("ign", vecs[1].bits, 9, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ign_no_done", 32'(done), 32'd0);
      chk("ign_no_busy", 32'(busy), 32'd0);
      chk("ign_tx_idle", 32'(tx), 32'd1);
    end

    // Held load: 0x00, then 0x81 presented in the done cycle starts next cycle.
    load    = 1'b1;
    data_in = 8'h00;
    run_frame("b2b_00", vecs[2].bits, -1, 1'b1);
    data_in = 8'h81;
    run_frame("b2b_81", vecs[4].bits, -1, 1'b0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in cycle 17 of a 0x55 frame.
    load    = 1'b1;
    data_in = 8'h55;
    @(negedge clk);
    load = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst_mid_pre_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end

    // Random stream with gaps, decoded by the monitor.
    mon_en   = 1'b1;
    accepted = 0;
    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      t = 0;
      while (!ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("sb_ready_timeout", 32'(ready), 32'd1);
      load    = 1'b1;
      data_in = 8'($urandom);
      exp_q.push_back(data_in);
      accepted++;
      @(negedge clk);
      load    = 1'b0;
      data_in = 8'($urandom);
    end
    t = 0;
    while ((rx_q.size() < 50 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("sb_count", 32'(rx_q.size()), 32'd50);
    for (int i = 0; i < 50 && i < rx_q.size(); i++) begin
      chk($sformatf("sb_word%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk("sb_done_count", 32'(done_cnt), 32'(accepted));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_nbit.md
Name: uart_tx_nbit

Overview:
- Serial transmitter for the CPU output path. Accepts a parallel word with the same load/data_in strobe used by the bus registers. Shifts the word out as an asynchronous UART frame: 1 start bit, N data bits LSB first, 1 stop bit, no parity.
- It is the outbound counterpart of the bus-loaded registers. The OUT instruction strobes `load` instead of latching a display register.

Parameters:
- N, 8, data word width; legal range 5..9.
- CLKS_PER_BIT, 4, clk cycles per serial bit; minimum 2. Synthesis uses clk_hz/baud, simulation uses 4.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- reset, input, 1, asynchronous active-high reset; clears all state immediately.
- load, input, 1, request to transmit data_in; sampled on the rising clk edge.
- data_in, input, N, word to transmit; captured only on an accepted load.
- ready, output, 1, high when a load will be accepted this cycle; equals NOT busy.
- busy, output, 1, high from the cycle after acceptance through the last stop-bit cycle.
- done, output, 1, one-cycle pulse in the first cycle after the stop bit completes.
- tx, output, 1, serial line; idles high; registered, no combinational path from inputs.

Behaviour:
- Reset values (asserted asynchronously, held while reset=1): tx=1, busy=0, ready=1, done=0, state=IDLE, shift register=0, bit/baud counters=0.
- States are IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If load=1 at a clk edge: capture data_in into the shift register, clear the baud counter, go to START.
  - Only an accepted load changes state.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after the accepting edge.
  - Then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit period: shift right by one and increment the bit index.
  - After bit N-1 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - done=1 for the single cycle in which the state first reads IDLE again.
- Frame length: tx departs idle exactly (N+2)*CLKS_PER_BIT cycles per frame, measured from the cycle after the accepting edge.
- Load handling:
  - load while busy=1 is ignored. No queueing, no effect on the frame in flight, data_in not captured.
  - load asserted in the done cycle is accepted, because ready=1 in that cycle. START begins the next cycle, giving a back-to-back stream with no idle gap beyond the stop bit.
  - A held-high load transmits the same word repeatedly, one frame per acceptance.
  - data_in changes after acceptance do not affect the frame in flight.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at the bit boundary.
  - Bit counter width is clog2(N). It never wraps past N-1.
- Reset mid-frame aborts immediately: tx returns to 1 asynchronously, and the partial frame is not resumed after reset release.
- A line receiver sees a truncated frame (framing error). This is acceptable and is not signalled.
- Illegal parameters: an elaboration-time assertion fails if CLKS_PER_BIT<2 or N is outside 5..9.

Decomposition:
- Shared package uart_pkg:
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}
  - localparam UART_STOP_BITS=1
  - helper for counter widths (clog2 wrapper)
- The future receiver imports the same package.
- One sub-module, baud_tick_gen:
  - Inputs: clk, reset, clear.
  - Output: tick, a one-cycle pulse every CLKS_PER_BIT cycles after clear.
  - The FSM and shift register stay in uart_tx_nbit.

Test Plan (N=8, CLKS_PER_BIT=4):
- Reset then idle 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
- load=1 with data_in=8'hA5 for one cycle:
  - tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. Start bit, LSB-first 0xA5, stop bit.
  - busy high for 40 cycles.
  - done pulses exactly 40 cycles after the accepting edge.
- load=1 with 8'h3C, then load=1 with 8'hFF at cycle 10 mid-frame -> the second load is ignored. The frame carries 0x3C, and only one done pulse occurs.
- load held high with data_in=8'h00, then 8'h81 presented in the done cycle:
  - The second frame starts the cycle after done; no extra idle cycles.
  - The frames decode as 0x00 then 0x81.
- Reset asserted asynchronously at cycle 17 of a 0x55 frame:
  - tx=1 and busy=0 before the next clk edge.
  - After release, tx stays 1 until a new load.
- Scoreboard: 50 random words with random 0–5 cycle gaps, decoded by a bit-sampling monitor at mid-bit -> all words match, stop bit is always 1, and done count equals accepted-load count.
